// File: rtl/seg_display_ctrl_if.sv
// Requester handshake and display-peripheral write bus for seg_display_ctrl.
// master = requester/peripheral side, slave = the controller.
interface seg_display_ctrl_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [13:0] req0_value;
  logic [3:0]  req0_dot;
  logic        req1_valid;
  logic        req1_ready;
  logic [13:0] req1_value;
  logic [3:0]  req1_dot;
  logic [7:0]  wr_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        done;
  logic        done_id;
  logic        ovf;

  modport master (
    output req0_valid, req0_value, req0_dot,
    output req1_valid, req1_value, req1_dot,
    input  req0_ready, req1_ready,
    input  wr_addr, wr_strb, wr_data, done, done_id, ovf
  );

  modport slave (
    input  req0_valid, req0_value, req0_dot,
    input  req1_valid, req1_value, req1_dot,
    output req0_ready, req1_ready,
    output wr_addr, wr_strb, wr_data, done, done_id, ovf
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Two-requester 4-digit 7-segment display controller: arbitrate, clamp, double-dabble, write.
// Optional macro SEG_BLANK_LEADING_ZERO_EN clears enables of leading-zero digits above digit 0.
//
// state | meaning
// IDLE  | waiting for a request, ready offered to the granted requester
// CONV  | 14 shift-add-3 cycles, one binary bit per cycle
// WDATA | digit word written to address 0
// WMODE | scan-all mode written to address 1, done pulsed
module seg_display_ctrl (
  input  logic               clk,
  input  logic               rstn,
  seg_display_ctrl_if.slave  bus_if
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] WDATA = 2'd2;
  localparam logic [1:0] WMODE = 2'd3;

  localparam logic [13:0] MAX_VAL = 14'd9999;

  logic [1:0]  state_q;
  logic        ptr_q;
  logic        id_q;
  logic [3:0]  dot_q;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        ovf_q;
  logic [7:0]  wr_addr_q;
  logic [3:0]  wr_strb_q;
  logic [31:0] wr_data_q;
  logic        done_q;
  logic        done_id_q;

  logic        idle;
  logic        gnt1;
  logic        ready0;
  logic        ready1;
  logic        xfer;
  logic [13:0] sel_value;
  logic [3:0]  sel_dot;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_d;
  logic [3:0]  en;
  logic [31:0] word_d;

  // Requester 1 wins when it is the sole valid one or the pointer names it.
  assign idle   = (state_q == IDLE);
  assign gnt1   = bus_if.req1_valid & (~bus_if.req0_valid | ptr_q);
  assign ready0 = idle & bus_if.req0_valid & ~gnt1;
  assign ready1 = idle & gnt1;
  assign xfer   = ready0 | ready1;

  assign sel_value = ready1 ? bus_if.req1_value : bus_if.req0_value;
  assign sel_dot   = ready1 ? bus_if.req1_dot   : bus_if.req0_dot;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[14:0], bin_q[13]};
  end

`ifdef SEG_BLANK_LEADING_ZERO_EN
  assign en[3] = |bcd_d[15:12];
  assign en[2] = |bcd_d[15:8];
  assign en[1] = |bcd_d[15:4];
  assign en[0] = 1'b1;
`else
  assign en = 4'hF;
`endif

  // Assembled from bcd_d so the last shift lands directly in the WDATA word.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < 4; k++) begin
      word_d[8*k +: 8] = {2'b00, en[k], dot_q[k], bcd_d[4*k +: 4]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      id_q      <= 1'b0;
      dot_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_strb_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            id_q    <= ready1;
            ptr_q   <= ~ready1;
            dot_q   <= sel_dot;
            bin_q   <= (sel_value > MAX_VAL) ? MAX_VAL : sel_value;
            ovf_q   <= (sel_value > MAX_VAL);
            bcd_q   <= '0;
            cnt_q   <= 4'd13;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_d;
          bin_q <= {bin_q[12:0], 1'b0};
          if (cnt_q == 4'd0) begin
            state_q   <= WDATA;
            wr_addr_q <= 8'd0;
            wr_strb_q <= 4'b1111;
            wr_data_q <= word_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WDATA: begin
          state_q   <= WMODE;
          wr_addr_q <= 8'd1;
          wr_strb_q <= 4'b0001;
          wr_data_q <= 32'h0000_000F;
          done_q    <= 1'b1;
          done_id_q <= id_q;
        end
        default: begin
          state_q   <= IDLE;
          wr_addr_q <= '0;
          wr_strb_q <= '0;
          wr_data_q <= '0;
        end
      endcase
    end
  end

  assign bus_if.req0_ready = ready0;
  assign bus_if.req1_ready = ready1;
  assign bus_if.wr_addr    = wr_addr_q;
  assign bus_if.wr_strb    = wr_strb_q;
  assign bus_if.wr_data    = wr_data_q;
  assign bus_if.done       = done_q;
  assign bus_if.done_id    = done_id_q;
  assign bus_if.ovf        = ovf_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl; expected words hand-derived per byte {2'b0,en,dot,bcd}.
module tb_seg_display_ctrl;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  seg_display_ctrl_if bus_if ();
  seg_display_ctrl dut (.clk(clk), .rstn(rstn), .bus_if(bus_if));

`ifdef SEG_BLANK_LEADING_ZERO_EN
  localparam logic [31:0] EXP_0 = 32'h00000020, EXP_3 = 32'h00000023, EXP_5 = 32'h00000025;
  localparam logic [31:0] EXP_7 = 32'h00000027, EXP_10 = 32'h00002120, EXP_42 = 32'h00002422;
`else
  localparam logic [31:0] EXP_0 = 32'h20202020, EXP_3 = 32'h20202023, EXP_5 = 32'h20202025;
  localparam logic [31:0] EXP_7 = 32'h20202027, EXP_10 = 32'h20202120, EXP_42 = 32'h20202422;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  bit          o_got;
  int          o_gcyc;
  logic        o_other_rdy, o_ovf, o_done15, o_done16, o_done17, o_id16;
  logic [3:0]  o_strb14, o_strb15, o_strb16, o_strb17;
  logic [7:0]  o_addr15, o_addr16;
  logic [31:0] o_data15, o_data16;

  // Drives one request from a point just after a negedge, records what the DUT does
  // at T, T+1, T+14..T+17, and returns 1 ns after the negedge of cycle T+17.
  task automatic serve(input bit id, input logic [13:0] val, input logic [3:0] dot);
    if (id) begin
      bus_if.req1_value = val; bus_if.req1_dot = dot; bus_if.req1_valid = 1'b1;
    end else begin
      bus_if.req0_value = val; bus_if.req0_dot = dot; bus_if.req0_valid = 1'b1;
    end
    #1;
    o_got = 1'b0;
    for (int i = 0; i < 40 && !o_got; i++) begin
      if ((id ? bus_if.req1_ready : bus_if.req0_ready) === 1'b1) o_got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    if (!o_got) begin
      if (id) bus_if.req1_valid = 1'b0; else bus_if.req0_valid = 1'b0;
      return;
    end
    o_gcyc      = cyc;
    o_other_rdy = id ? bus_if.req0_ready : bus_if.req1_ready;
    @(negedge clk);
    if (id) bus_if.req1_valid = 1'b0; else bus_if.req0_valid = 1'b0;
    #1 o_ovf = bus_if.ovf;
    repeat (13) @(negedge clk);
    #1 o_strb14 = bus_if.wr_strb;
    @(negedge clk); #1;
    o_addr15 = bus_if.wr_addr; o_strb15 = bus_if.wr_strb; o_data15 = bus_if.wr_data; o_done15 = bus_if.done;
    @(negedge clk); #1;
    o_addr16 = bus_if.wr_addr; o_strb16 = bus_if.wr_strb; o_data16 = bus_if.wr_data;
    o_done16 = bus_if.done; o_id16 = bus_if.done_id;
    @(negedge clk); #1;
    o_strb17 = bus_if.wr_strb; o_done17 = bus_if.done;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
    bus_if.req0_value = '0; bus_if.req1_value = '0; bus_if.req0_dot = '0; bus_if.req1_dot = '0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus_if.wr_strb !== 4'h0) begin n_bad++; $display("FAIL reset_strb: got %h want 0", bus_if.wr_strb); end
    n_cmp++; if (bus_if.wr_addr !== 8'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus_if.wr_addr); end
    n_cmp++; if (bus_if.wr_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus_if.wr_data); end
    n_cmp++; if ({bus_if.done, bus_if.done_id, bus_if.ovf} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {bus_if.done, bus_if.done_id, bus_if.ovf}); end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    serve(1'b0, 14'd1234, 4'b0100);
    n_cmp++; if (o_got !== 1'b1) begin n_bad++; $display("FAIL single_grant: got %b want 1", o_got); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL single_ovf: got %b want 0", o_ovf); end
    n_cmp++; if (o_strb14 !== 4'h0) begin n_bad++; $display("FAIL single_strb_conv: got %h want 0", o_strb14); end
    n_cmp++; if ({o_addr15, o_strb15, o_done15} !== {8'h00, 4'hF, 1'b0}) begin
      n_bad++; $display("FAIL single_wdata_ctl: got %h/%h/%b want 00/f/0", o_addr15, o_strb15, o_done15); end
    n_cmp++; if (o_data15 !== 32'h21322324) begin n_bad++; $display("FAIL single_wdata: got %h want 21322324", o_data15); end
    n_cmp++; if ({o_addr16, o_strb16, o_data16} !== {8'h01, 4'h1, 32'h0000000F}) begin
      n_bad++; $display("FAIL single_wmode: got %h/%h/%h want 01/1/0000000f", o_addr16, o_strb16, o_data16); end
    n_cmp++; if ({o_done16, o_id16} !== 2'b10) begin n_bad++; $display("FAIL single_done: got %b want 10", {o_done16, o_id16}); end
    n_cmp++; if ({o_strb17, o_done17} !== 5'b0) begin n_bad++; $display("FAIL single_idle: got %h want 0", {o_strb17, o_done17}); end
  endtask

  task automatic test_round_robin();
    int g0;
    pulse_reset();
    bus_if.req1_value = 14'd7; bus_if.req1_dot = 4'b0000; bus_if.req1_valid = 1'b1;
    serve(1'b0, 14'd5, 4'b0000);
    g0 = o_gcyc;
    n_cmp++; if ({o_got, o_other_rdy} !== 2'b10) begin n_bad++; $display("FAIL rr_first: got %b want 10", {o_got, o_other_rdy}); end
    n_cmp++; if (o_data15 !== EXP_5) begin n_bad++; $display("FAIL rr_data0: got %h want %h", o_data15, EXP_5); end
    n_cmp++; if (o_id16 !== 1'b0) begin n_bad++; $display("FAIL rr_id0: got %b want 0", o_id16); end
    serve(1'b1, 14'd7, 4'b0000);
    n_cmp++; if (o_got !== 1'b1 || o_gcyc - g0 != 17) begin
      n_bad++; $display("FAIL rr_second_spacing: got %0d want 17", o_gcyc - g0); end
    n_cmp++; if (o_data15 !== EXP_7) begin n_bad++; $display("FAIL rr_data1: got %h want %h", o_data15, EXP_7); end
    n_cmp++; if ({o_done16, o_id16} !== 2'b11) begin n_bad++; $display("FAIL rr_done1: got %b want 11", {o_done16, o_id16}); end
  endtask

  task automatic test_ovf();
    serve(1'b0, 14'd12000, 4'b0000);
    n_cmp++; if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_12000: got %b want 1", o_ovf); end
    n_cmp++; if (o_data15 !== 32'h29292929) begin n_bad++; $display("FAIL ovf_data: got %h want 29292929", o_data15); end
    serve(1'b0, 14'd9999, 4'b0000);
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_9999: got %b want 0", o_ovf); end
    n_cmp++; if (o_data15 !== 32'h29292929) begin n_bad++; $display("FAIL data_9999: got %h want 29292929", o_data15); end
    serve(1'b1, 14'd10000, 4'b1111);
    n_cmp++; if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_10000: got %b want 1", o_ovf); end
    n_cmp++; if (o_data15 !== 32'h39393939) begin n_bad++; $display("FAIL data_10000_dots: got %h want 39393939", o_data15); end
  endtask

  task automatic test_blank();
    serve(1'b0, 14'd42, 4'b0000);
    n_cmp++; if (o_data15 !== EXP_42) begin n_bad++; $display("FAIL blank_42: got %h want %h", o_data15, EXP_42); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL blank_ovf: got %b want 0", o_ovf); end
  endtask

  task automatic test_reset_mid();
    bit seen, got;
    bus_if.req0_value = 14'd1234; bus_if.req0_dot = 4'b0000; bus_if.req0_valid = 1'b1;
    #1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus_if.req0_ready === 1'b1) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL mid_grant: got %b want 1", got); end
    @(negedge clk); bus_if.req0_valid = 1'b0;
    repeat (7) @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++; if ({bus_if.wr_strb, bus_if.done} !== 5'b0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %h want 0", {bus_if.wr_strb, bus_if.done}); end
    @(negedge clk); rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk); #1;
      if (bus_if.wr_strb !== 4'h0 || bus_if.done !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_write: got %b want 0", seen); end
    bus_if.req1_value = 14'd8; bus_if.req1_dot = 4'b0000; bus_if.req1_valid = 1'b1;
    bus_if.req0_valid = 1'b1;
    #1;
    n_cmp++; if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin
      n_bad++; $display("FAIL mid_ptr_restored: got %b want 10", {bus_if.req0_ready, bus_if.req1_ready}); end
    serve(1'b0, 14'd3, 4'b0000);
    bus_if.req1_valid = 1'b0;
    n_cmp++; if (o_data15 !== EXP_3 || o_id16 !== 1'b0) begin
      n_bad++; $display("FAIL mid_next_served: got %h/%b want %h/0", o_data15, o_id16, EXP_3); end
  endtask

  task automatic test_back_to_back();
    int g0;
    @(negedge clk); #1;
    serve(1'b1, 14'd0, 4'b0000);
    g0 = o_gcyc;
    n_cmp++; if (o_got !== 1'b1 || o_data15 !== EXP_0) begin
      n_bad++; $display("FAIL b2b_first: got %b/%h want 1/%h", o_got, o_data15, EXP_0); end
    serve(1'b1, 14'd9999, 4'b0000);
    n_cmp++; if (o_got !== 1'b1 || o_gcyc - g0 != 17) begin
      n_bad++; $display("FAIL b2b_spacing2: got %0d want 17", o_gcyc - g0); end
    g0 = o_gcyc;
    serve(1'b1, 14'd10, 4'b0000);
    n_cmp++; if (o_got !== 1'b1 || o_gcyc - g0 != 17) begin
      n_bad++; $display("FAIL b2b_spacing3: got %0d want 17", o_gcyc - g0); end
    n_cmp++; if (o_data15 !== EXP_10 || o_id16 !== 1'b1) begin
      n_bad++; $display("FAIL b2b_data3: got %h/%b want %h/1", o_data15, o_id16, EXP_10); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ovf();
    test_blank();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
